// File: rtl/door_sequencer_if.sv
// Signal bundle between the door sequencer and its surroundings: requests,
// limit/beam sensors in; motor control, grant and state reporting out.
interface door_sequencer_if;
  logic       Btn_Req;
  logic       Rmt_Req;
  logic       Up_Max;
  logic       Dn_Max;
  logic       Obstruct;
  logic       Clr_Fault;
  logic       Activate;
  logic       Motor_En;
  logic       Fault;
  logic [1:0] Grant;
  logic [2:0] Door_State;

  modport master (
    output Btn_Req, Rmt_Req, Up_Max, Dn_Max, Obstruct, Clr_Fault,
    input  Activate, Motor_En, Fault, Grant, Door_State
  );

  modport slave (
    input  Btn_Req, Rmt_Req, Up_Max, Dn_Max, Obstruct, Clr_Fault,
    output Activate, Motor_En, Fault, Grant, Door_State
  );
endinterface

// File: rtl/door_sequencer.sv
// Door open/close sequencer: edge-detected requests, auto-close timer,
// travel watchdog and latched fault with explicit clear.
module door_sequencer #(
  parameter int AUTO_CLOSE_CYC = 1000,
  parameter int TRAVEL_MAX_CYC = 500,
  parameter int CNT_W          = 16
) (
  input logic             CLK,
  input logic             RST,
  door_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    CLOSED  = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] AC_LOAD = CNT_W'(AUTO_CLOSE_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TRAVEL_MAX_CYC - 1);

  state_t           state, nxt;
  logic             btn_q, rmt_q;
  logic             btn_edge, rmt_edge;
  logic [CNT_W-1:0] timer, wd;
  logic             act_q;
  logic [1:0]       grant_q, grant_nxt;
  logic             travel_entry;
  logic             open_entry;

  assign btn_edge     = io.Btn_Req & ~btn_q;
  assign rmt_edge     = io.Rmt_Req & ~rmt_q;
  assign travel_entry = (nxt == OPENING || nxt == CLOSING) && (nxt != state);
  assign open_entry   = (nxt == OPEN) && (state != OPEN);

  // State register; Activate/Grant are registered so they land on the
  // first cycle of the new travel state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= SYNC;
      btn_q   <= 1'b0;
      rmt_q   <= 1'b0;
      act_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state   <= nxt;
      btn_q   <= io.Btn_Req;
      rmt_q   <= io.Rmt_Req;
      act_q   <= travel_entry;
      grant_q <= grant_nxt;
    end
  end

  // Auto-close timer counts down to 0, watchdog counts up to all-ones; both hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
      wd    <= '0;
    end else begin
      if (open_entry || (state == OPEN && io.Obstruct))
        timer <= AC_LOAD;
      else if (state == OPEN && timer != '0)
        timer <= timer - 1'b1;

      if (travel_entry)
        wd <= '0;
      else if ((state == OPENING || state == CLOSING) && wd != '1)
        wd <= wd + 1'b1;
    end
  end

  always_comb begin
    nxt       = state;
    grant_nxt = 2'b00;
    unique case (state)
      SYNC: begin
        if (io.Dn_Max && !io.Up_Max)      nxt = CLOSED;
        else if (io.Up_Max && !io.Dn_Max) nxt = OPEN;
        else                              nxt = FAULT;
      end
      CLOSED: begin
        if (btn_edge || rmt_edge) begin
          nxt       = OPENING;
          grant_nxt = btn_edge ? 2'b01 : 2'b10;
        end
      end
      OPENING: begin
        if (io.Up_Max)         nxt = OPEN;
        else if (wd >= WD_LAST) nxt = FAULT;
      end
      // An obstructed doorway swallows both requests and the timeout.
      OPEN: begin
        if (!io.Obstruct && (btn_edge || rmt_edge || timer == '0)) begin
          nxt = CLOSING;
          if (btn_edge)      grant_nxt = 2'b01;
          else if (rmt_edge) grant_nxt = 2'b10;
        end
      end
      CLOSING: begin
        if (io.Obstruct)        nxt = FAULT;
        else if (io.Dn_Max)     nxt = CLOSED;
        else if (wd >= WD_LAST) nxt = FAULT;
      end
      FAULT: begin
        if (io.Clr_Fault) nxt = SYNC;
      end
      default: nxt = FAULT;
    endcase
  end

  always_comb begin
    io.Door_State = state;
    io.Motor_En   = (state == CLOSED) || (state == OPENING) ||
                    (state == OPEN)   || (state == CLOSING);
    io.Fault      = (state == FAULT);
    io.Activate   = act_q;
    io.Grant      = grant_q;
  end

endmodule
